// File: rtl/line_scanner_pkg.sv
// Shared types and constants for the one-hot line-select scanner.
package scanner_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // A dwell of 1 still needs a 1-bit counter so the compare logic stays uniform.
    function automatic int cnt_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/line_scanner_if.sv
// Control/status bundle between the readout sequencer and the line scanner.
interface line_scanner_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic          start;
    logic          adv;
    logic          dir;
    logic          cont;
    logic          abort;
    logic [N-1:0]  sel;
    logic [IW-1:0] idx;
    logic          busy;
    logic          done;

    modport master (
        output start, adv, dir, cont, abort,
        input  sel, idx, busy, done
    );

    modport slave (
        input  start, adv, dir, cont, abort,
        output sel, idx, busy, done
    );
endinterface

// File: rtl/line_scanner_dwell_counter.sv
// Counts adv-qualified cycles on one line; tick marks the final cycle of the dwell.
module dwell_counter
    import scanner_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int             CW   = cnt_width(DWELL);
    localparam logic [CW-1:0]  LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end
endmodule

// File: rtl/line_scanner.sv
// One-hot line-select scanner: walks a single token across N select lines.
//   state | meaning
//   IDLE  | no line selected, waiting for start
//   SCAN  | token on line idx, advancing every DWELL adv-qualified cycles
module line_scanner
    import scanner_pkg::*;
#(
    parameter int N     = 4,
    parameter int DWELL = 1
) (
    input  logic           clk,
    input  logic           reset,
    line_scanner_if.slave  bus
);
    localparam int            IW      = $clog2(N);
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
    localparam logic [N-1:0]  SEL_TOP = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  SEL_BOT = {{(N-1){1'b0}}, 1'b1};

    scan_state_t   state, state_nxt;
    logic [N-1:0]  sel_q, sel_nxt;
    logic [IW-1:0] idx_q, idx_nxt;
    logic          dir_q, dir_nxt;
    logic          cont_q, cont_nxt;
    logic          done_q, done_nxt;
    logic          tick;
    logic          at_last;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clr   ((state == IDLE) || bus.abort),
        .en    ((state == SCAN) && bus.adv),
        .tick  (tick)
    );

    assign at_last = (dir_q == DIR_UP) ? (idx_q == IDX_TOP) : (idx_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sel_q  <= '0;
            idx_q  <= '0;
            dir_q  <= DIR_DOWN;
            cont_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            sel_q  <= sel_nxt;
            idx_q  <= idx_nxt;
            dir_q  <= dir_nxt;
            cont_q <= cont_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        idx_nxt   = idx_q;
        dir_nxt   = dir_q;
        cont_nxt  = cont_q;
        done_nxt  = 1'b0;
        if (bus.abort) begin
            state_nxt = IDLE;
            sel_nxt   = '0;
            idx_nxt   = '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                state_nxt = SCAN;
                dir_nxt   = bus.dir;
                cont_nxt  = bus.cont;
                sel_nxt   = (bus.dir == DIR_UP) ? SEL_BOT : SEL_TOP;
                idx_nxt   = (bus.dir == DIR_UP) ? '0 : IDX_TOP;
            end
        end else if (tick) begin
            if (at_last) begin
                done_nxt = 1'b1;
                if (cont_q) begin
                    sel_nxt = (dir_q == DIR_UP) ? SEL_BOT : SEL_TOP;
                    idx_nxt = (dir_q == DIR_UP) ? '0 : IDX_TOP;
                end else begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                    idx_nxt   = '0;
                end
            end else if (dir_q == DIR_UP) begin
                sel_nxt = sel_q << 1;
                idx_nxt = idx_q + IW'(1);
            end else begin
                sel_nxt = sel_q >> 1;
                idx_nxt = idx_q - IW'(1);
            end
        end
    end

    assign bus.sel  = sel_q;
    assign bus.idx  = idx_q;
    assign bus.busy = (state == SCAN);
    assign bus.done = done_q;
endmodule

// File: tb/tb_line_scanner.sv
// Bench for line_scanner: table vectors, corner sequences and random traffic vs. a pass-count model.
module tb_line_scanner;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic adv   = 1'b0;
    logic dir   = 1'b0;
    logic cont  = 1'b0;
    logic abort = 1'b0;

    always #5 clk = ~clk;

    line_scanner_if #(.N(N)) b1 ();
    line_scanner_if #(.N(N)) b3 ();

    assign b1.start = start;  assign b3.start = start;
    assign b1.adv   = adv;    assign b3.adv   = adv;
    assign b1.dir   = dir;    assign b3.dir   = dir;
    assign b1.cont  = cont;   assign b3.cont  = cont;
    assign b1.abort = abort;  assign b3.abort = abort;

    line_scanner #(.N(N), .DWELL(1)) u_d1 (.clk(clk), .reset(rst_n), .bus(b1));
    line_scanner #(.N(N), .DWELL(3)) u_d3 (.clk(clk), .reset(rst_n), .bus(b3));

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a pass is N*DWELL adv-high cycles; the line is simply k/DWELL from the starting end.
    bit m_active [2];
    bit m_dir    [2];
    bit m_cont   [2];
    int m_k      [2];
    bit m_done   [2];

    function automatic int dw(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_dir[i] = 0; m_cont[i] = 0; m_k[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 0;
            if (!rst_n || abort) begin
                m_active[i] = 0;
                m_k[i] = 0;
            end else if (!m_active[i]) begin
                if (start) begin
                    m_active[i] = 1; m_dir[i] = dir; m_cont[i] = cont; m_k[i] = 0;
                end
            end else if (adv) begin
                m_k[i]++;
                if (m_k[i] == N * dw(i)) begin
                    m_done[i] = 1;
                    m_k[i] = 0;
                    if (!m_cont[i]) m_active[i] = 0;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_idx(input int i);
        int line;
        if (!m_active[i]) return 0;
        line = m_k[i] / dw(i);
        return m_dir[i] ? line : (N - 1 - line);
    endfunction

    function automatic logic [31:0] exp_sel(input int i);
        if (!m_active[i]) return 0;
        return 32'(1) << exp_idx(i);
    endfunction

    task automatic check_models();
        chk("d1_sel",  32'(b1.sel),  exp_sel(0));
        chk("d1_idx",  32'(b1.idx),  exp_idx(0));
        chk("d1_busy", 32'(b1.busy), 32'(m_active[0]));
        chk("d1_done", 32'(b1.done), 32'(m_done[0]));
        chk("d3_sel",  32'(b3.sel),  exp_sel(1));
        chk("d3_idx",  32'(b3.idx),  exp_idx(1));
        chk("d3_busy", 32'(b3.busy), 32'(m_active[1]));
        chk("d3_done", 32'(b3.done), 32'(m_done[1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_models();
    endtask

    task automatic set_in(input logic s, input logic a, input logic d, input logic c, input logic ab);
        start = s; adv = a; dir = d; cont = c; abort = ab;
    endtask

    typedef struct {
        logic       s, a, d, c, ab;
        logic [3:0] sel;
        logic [1:0] idx;
        logic       busy, done;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic s, input logic a, input logic d, input logic c, input logic ab,
                                input logic [3:0] sel, input logic [1:0] idx, input logic busy, input logic done);
        vec_t v;
        v.s = s; v.a = a; v.d = d; v.c = c; v.ab = ab;
        v.sel = sel; v.idx = idx; v.busy = busy; v.done = done;
        return v;
    endfunction

    initial begin
        logic [3:0] s3_exp [9] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010};
        logic       s3_adv [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int dones;

        // one-shot down, one-shot up with dir toggling mid-pass
        tbl.push_back(mk(1,1,0,0,0, 4'b1000, 3, 1, 0));
        tbl.push_back(mk(0,1,0,0,0, 4'b0100, 2, 1, 0));
        tbl.push_back(mk(0,1,0,0,0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0,1,0,0,0, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(0,1,0,0,0, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(0,1,0,0,0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1,1,1,0,0, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(0,1,0,0,0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0,1,1,0,0, 4'b0100, 2, 1, 0));
        tbl.push_back(mk(0,1,0,0,0, 4'b1000, 3, 1, 0));
        tbl.push_back(mk(0,1,1,0,0, 4'b0000, 0, 0, 1));
        tbl.push_back(mk(0,1,1,0,0, 4'b0000, 0, 0, 0));
        // start while busy, abort mid-pass, start+abort from idle, abort on the last-line step
        tbl.push_back(mk(1,1,0,0,0, 4'b1000, 3, 1, 0));
        tbl.push_back(mk(1,1,1,1,0, 4'b0100, 2, 1, 0));
        tbl.push_back(mk(1,1,1,1,0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0,1,0,0,1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0,1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0,0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1,1,0,0,0, 4'b1000, 3, 1, 0));
        tbl.push_back(mk(0,1,0,0,0, 4'b0100, 2, 1, 0));
        tbl.push_back(mk(0,1,0,0,0, 4'b0010, 1, 1, 0));
        tbl.push_back(mk(0,1,0,0,0, 4'b0001, 0, 1, 0));
        tbl.push_back(mk(0,1,0,0,1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0,0, 4'b0000, 0, 0, 0));

        model_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        foreach (tbl[j]) begin
            set_in(tbl[j].s, tbl[j].a, tbl[j].d, tbl[j].c, tbl[j].ab);
            cyc();
            chk("tbl_sel",  32'(b1.sel),  32'(tbl[j].sel));
            chk("tbl_idx",  32'(b1.idx),  32'(tbl[j].idx));
            chk("tbl_busy", 32'(b1.busy), 32'(tbl[j].busy));
            chk("tbl_done", 32'(b1.done), 32'(tbl[j].done));
        end

        // DWELL=3 with adv gaps: count freezes while adv is low
        set_in(0, 0, 0, 0, 1);
        cyc();
        set_in(1, 0, 0, 0, 0);
        cyc();
        chk("dw3_first", 32'(b3.sel), 32'(4'b1000));
        start = 1'b0;
        for (int j = 0; j < 9; j++) begin
            adv = s3_adv[j];
            cyc();
            chk("dw3_hold", 32'(b3.sel), 32'(s3_exp[j]));
        end

        // continuous wrap for three passes, then abort without done
        set_in(0, 1, 0, 0, 1);
        cyc();
        set_in(1, 1, 0, 1, 0);
        cyc();
        start = 1'b0;
        dones = 0;
        for (int j = 0; j < 12; j++) begin
            cyc();
            if (b1.done === 1'b1) begin
                dones++;
                chk("wrap_sel", 32'(b1.sel), 32'(4'b1000));
            end
        end
        chk("wrap_passes", 32'(dones), 32'd3);
        abort = 1'b1;
        cyc();
        chk("abort_sel",  32'(b1.sel),  32'd0);
        chk("abort_busy", 32'(b1.busy), 32'd0);
        chk("abort_done", 32'(b1.done), 32'd0);

        // asynchronous reset between edges while on line 2
        set_in(1, 1, 0, 0, 0);
        cyc();
        start = 1'b0;
        cyc();
        chk("pre_rst_idx", 32'(b1.idx), 32'd2);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_sel",  32'(b1.sel),  32'd0);
        chk("rst_idx",  32'(b1.idx),  32'd0);
        chk("rst_busy", 32'(b1.busy), 32'd0);
        chk("rst_d3_busy", 32'(b3.busy), 32'd0);
        cyc();
        #2;
        rst_n = 1'b1;
        repeat (3) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("post_rst_sel", 32'(b1.sel), 32'(4'b1000));
        chk("post_rst_idx", 32'(b1.idx), 32'd3);

        // random traffic against the model
        for (int j = 0; j < 800; j++) begin
            set_in($urandom_range(0, 5) == 0, ($urandom % 4) != 0, 1'($urandom),
                   1'($urandom), $urandom_range(0, 39) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/line_scanner.md
# line_scanner

Parametrised one-hot line-select scanner for the pixel-array readout path. It replaces the fixed 4-bit read shift register. On `start` it loads a single token at the first line and steps it across N select lines, holding each line for a programmable dwell. It supports both scan directions, one-shot or continuous (wrap) mode, abort, and an end-of-pass pulse for the readout sequencer.

## Interface
Parameters:
- `N`, 4: number of select lines; must be ≥ 2.
- `DWELL`, 1: `adv`-qualified cycles per line; must be ≥ 1.
- `IW`, `$clog2(N)`: derived localparam; width of `idx`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a pass; honoured only in IDLE.
- `adv`  in  1  dwell/step enable; when low, the scan holds.
- `dir`  in  1  0 = down (line N-1 toward 0), 1 = up (line 0 toward N-1); sampled at `start`.
- `cont`  in  1  1 = wrap to the first line after the last; sampled at `start`.
- `abort`  in  1  terminate the scan immediately.
- `sel`  out  N  one-hot line select; all-zero when idle.
- `idx`  out  IW  binary index of the active line; 0 when idle.
- `busy`  out  1  high while in SCAN.
- `done`  out  1  one-cycle pulse at the end of each pass.

## Operation
- States: IDLE and SCAN.
- **IDLE**
  - Outputs: `sel`=0, `idx`=0, `busy`=0, dwell count=0.
  - `start`=1 and `abort`=0 → SCAN. Latch `dir` and `cont`. Load the token at the first line: N-1 if `dir`=0, 0 if `dir`=1. Set `idx` to that line and clear the dwell count.
- **SCAN**
  - `adv`=1: increment the dwell count.
  - A step occurs when `adv`=1 and count = DWELL-1. On a step, clear the count and move the token one line in the latched direction; `idx` follows.
  - `adv`=0: count, `sel` and `idx` hold.
- **Step from the last line** (0 if down, N-1 if up):
  - `cont`=0: go to IDLE with `sel`=0, `idx`=0, `busy`=0. `done`=1 for one cycle.
  - `cont`=1: wrap to the first line and stay in SCAN. `done`=1 for one cycle.
- **`abort`** in any state: next edge → IDLE with all outputs at idle values. No `done`. `abort` has priority over `start` and over a coincident step.
- `start` during SCAN is ignored. The latched `dir`/`cont` do not change mid-pass.
- Exactly one `sel` bit is high throughout SCAN, and `idx` always equals the position of that bit.
- Dwell counter width is `$clog2(DWELL)`, with a minimum of 1 bit. It never exceeds DWELL-1.

## Timing
- **Reset:** `reset`=0 forces IDLE, `sel`=0, `idx`=0, `busy`=0, `done`=0 and count=0 immediately, with no clock needed. This holds mid-scan. After release the block stays in IDLE until a `start`.
- **Start latency:** `start` sampled at edge k → `sel`, `idx` and `busy` valid after edge k.
- **Step rate:** with `adv` held high, the token moves every DWELL cycles. A one-shot pass keeps `busy` high for exactly N·DWELL cycles.
- **`done`:** registered. It is high in the same cycle that `sel` becomes 0 (one-shot) or returns to the first line (continuous).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `scanner_pkg`:
  - state enum typedef `scan_state_t` {IDLE, SCAN};
  - constants `DIR_DOWN`=1'b0 and `DIR_UP`=1'b1.
- One sub-module, `dwell_counter`:
  - parameter DWELL;
  - inputs `clk`, `reset`, `clr`, `en`;
  - output `tick`, high when `en` is high and count = DWELL-1.
- The top level holds the FSM, the token register and the index register.

## Test plan
1. N=4, DWELL=1, `dir`=0, `cont`=0, `adv`=1, pulse `start` → `sel` 1000, 0100, 0010, 0001 on consecutive cycles with `idx` 3, 2, 1, 0. Then `sel`=0000, `done`=1 for one cycle, `busy` falls.
2. Same as scenario 1 with `dir`=1 → `sel` 0001 through 1000, `idx` 0 through 3, `done` after line 3. Toggling `dir` mid-pass has no effect.
3. DWELL=3, `adv` pattern 1,1,0,0,1,1,1… → each line is held for exactly 3 `adv`-high cycles, and the count freezes while `adv`=0.
4. `cont`=1, `dir`=0 → after 0001 the next `sel` is 1000 with a `done` pulse. Scanning continues for 3 passes. Then `abort` → `sel`=0000 and `busy`=0 on the next edge, with no `done`.
5. `start` while busy → ignored, position unaffected. `start` and `abort` in the same cycle from IDLE → remains IDLE. `abort` coincident with a last-line step → IDLE, no `done`.
6. `reset` driven low between clock edges at line 2 → all outputs 0 immediately. After release, outputs stay idle until `start`, and the next pass begins at line 3 for `dir`=0.
